// File: rtl/psum_accumulator.sv
// Windowed accumulator for packed multiplier products with shift/saturate requantization.
// state | meaning
// ACC   | taking input beats, summing into the window accumulators
// OUT   | holding a finished result until downstream accepts it
module psum_accumulator #(
  parameter int PSUM_WIDTH     = 24,
  parameter int CNT_WIDTH      = 8,
  parameter int ACC_WIDTH      = PSUM_WIDTH + CNT_WIDTH,
  parameter int LANE_ACC_WIDTH = PSUM_WIDTH / 2 + CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic [4:0]            cfg_shift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_WIDTH-1:0] in_psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_sat
);

  localparam int HALF = PSUM_WIDTH / 2;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic signed [ACC_WIDTH-1:0]      Q8_MAX = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0]      Q8_MIN = ACC_WIDTH'(-128);
  localparam logic signed [LANE_ACC_WIDTH-1:0] Q4_MAX = LANE_ACC_WIDTH'(7);
  localparam logic signed [LANE_ACC_WIDTH-1:0] Q4_MIN = LANE_ACC_WIDTH'(-8);

  logic [0:0]                        state_q, state_d;
  logic [CNT_WIDTH-1:0]              count_q, count_d;
  logic signed [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic signed [LANE_ACC_WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic signed [LANE_ACC_WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic                              mode_q, mode_d;
  logic [CNT_WIDTH-1:0]              len_q, len_d;
  logic [4:0]                        shift_q, shift_d;
  logic                              out_valid_q, out_valid_d;
  logic [7:0]                        out_data_q, out_data_d;
  logic                              out_sat_q, out_sat_d;

  logic                              cur_mode;
  logic [CNT_WIDTH-1:0]              cur_len, eff_len;
  logic [4:0]                        cur_shift;
  logic                              in_fire, last_beat;
  logic signed [ACC_WIDTH-1:0]       sum_full, sh_full;
  logic signed [LANE_ACC_WIDTH-1:0]  sum_hi, sum_lo, sh_hi, sh_lo;
  logic [7:0]                        res8;
  logic [3:0]                        res_hi, res_lo;
  logic                              sat8, sat_hi, sat_lo;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign in_fire   = in_valid && in_ready;

  // The first beat of a window uses the live config; later beats use the latched copy.
  always_comb begin
    cur_mode  = (count_q == '0) ? mode      : mode_q;
    cur_len   = (count_q == '0) ? cfg_len   : len_q;
    cur_shift = (count_q == '0) ? cfg_shift : shift_q;
    eff_len   = (cur_len == '0) ? CNT_WIDTH'(1) : cur_len;
    last_beat = (count_q == eff_len - CNT_WIDTH'(1));

    sum_full = acc_q + ACC_WIDTH'($signed(in_psum));
    sum_hi   = acc_hi_q + LANE_ACC_WIDTH'($signed(in_psum[PSUM_WIDTH-1:HALF]));
    sum_lo   = acc_lo_q + LANE_ACC_WIDTH'($signed(in_psum[HALF-1:0]));
    sh_full  = sum_full >>> cur_shift;
    sh_hi    = sum_hi >>> cur_shift;
    sh_lo    = sum_lo >>> cur_shift;

    sat8 = 1'b0;
    res8 = sh_full[7:0];
    if (sh_full > Q8_MAX) begin
      sat8 = 1'b1;
      res8 = 8'h7F;
    end else if (sh_full < Q8_MIN) begin
      sat8 = 1'b1;
      res8 = 8'h80;
    end

    sat_hi = 1'b0;
    res_hi = sh_hi[3:0];
    if (sh_hi > Q4_MAX) begin
      sat_hi = 1'b1;
      res_hi = 4'h7;
    end else if (sh_hi < Q4_MIN) begin
      sat_hi = 1'b1;
      res_hi = 4'h8;
    end

    sat_lo = 1'b0;
    res_lo = sh_lo[3:0];
    if (sh_lo > Q4_MAX) begin
      sat_lo = 1'b1;
      res_lo = 4'h7;
    end else if (sh_lo < Q4_MIN) begin
      sat_lo = 1'b1;
      res_lo = 4'h8;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    mode_d      = mode_q;
    len_d       = len_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (state_q == ST_ACC) begin
      if (in_fire) begin
        mode_d  = cur_mode;
        len_d   = cur_len;
        shift_d = cur_shift;
        if (last_beat) begin
          out_data_d  = cur_mode ? {res_hi, res_lo} : res8;
          out_sat_d   = cur_mode ? (sat_hi || sat_lo) : sat8;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
          count_d     = '0;
          acc_d       = '0;
          acc_hi_d    = '0;
          acc_lo_d    = '0;
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
          if (cur_mode) begin
            acc_hi_d = sum_hi;
            acc_lo_d = sum_lo;
          end else begin
            acc_d = sum_full;
          end
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      acc_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
